// File: rtl/snes_video_src.sv
// snes_video_src
//   Synthetic SNES-style video and audio source used to exercise the
//   downstream converter without a real console attached.
//
//   Video: a phase counter divides clk into dots. Each dot lasts 2*DOT_HALF
//   clk cycles, and the dots are walked across a DOTS_PER_LINE x
//   LINES_PER_FRAME raster. The field bit toggles once per frame. Every
//   pixel-rate output is reloaded only on the cycle a dot starts, so it
//   holds steady for the whole dot.
//
//   Audio: a free-running divider produces one sawtooth sample every
//   AUDIO_DIV cycles, provided the sink is ready for it.
//
//   Ports
//     clk          : SNES clock domain
//     reset        : asynchronous, active-high
//     pause        : freezes every counter and output while high
//     mode[1:0]    : 0 gradient, 1 bars, 2 checker, 3 solid colour
//     solid[14:0]  : colour used in mode 3
//     audio_en     : sink can take a sample
//     dotclk       : dot clock, low for the first half of each dot
//     hblank       : h >= 256
//     vblank       : v >= 224
//     rgb5[14:0]   : {B,G,R} pixel, forced to 0 while blanked
//     xs[8:0]      : {x[7:0], dotclk}
//     ys[8:0]      : {field, y[7:0]}
//     snes_refresh : DRAM refresh window, in dots
//     audio_l/r    : sawtooth sample; right channel is the inverse of left
//     audio_ready  : one-cycle strobe marking a new sample
module snes_video_src #(
    parameter int          DOT_HALF        = 2,
    parameter int          DOTS_PER_LINE   = 341,
    parameter int          LINES_PER_FRAME = 262,
    parameter int          REFRESH_DOT     = 134,
    parameter int          REFRESH_LEN     = 10,
    parameter int          AUDIO_DIV       = 671,
    parameter logic [15:0] AUDIO_STEP      = 16'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pause,
    input  logic [1:0]  mode,
    input  logic [14:0] solid,
    input  logic        audio_en,
    output logic        dotclk,
    output logic        hblank,
    output logic        vblank,
    output logic [14:0] rgb5,
    output logic [8:0]  xs,
    output logic [8:0]  ys,
    output logic        snes_refresh,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic        audio_ready
);

    localparam int PH_LAST = 2 * DOT_HALF - 1;

    logic [7:0]  ph, ph_nx;
    logic [15:0] h, h_nx;
    logic [15:0] v, v_nx;
    logic        field, field_nx;
    logic        dot_start;

    logic [7:0]  x_nx, y_nx;
    logic [7:0]  x_q, y_q;
    logic        hb_nx, vb_nx, ref_nx;
    logic [14:0] pat_nx, rgb_nx;

    logic [15:0] div;
    logic        div_wrap;
    logic [15:0] l_sum;
    logic        ready_q;

    // Raster position for the next cycle. A dot starts on the cycle ph
    // wraps back to 0; that cycle carries the h, v and field increments.
    always_comb begin
        ph_nx     = ph + 8'd1;
        h_nx      = h;
        v_nx      = v;
        field_nx  = field;
        dot_start = 1'b0;
        if (ph == 8'(PH_LAST)) begin
            ph_nx     = '0;
            dot_start = 1'b1;
            if (h == 16'(DOTS_PER_LINE - 1)) begin
                h_nx = '0;
                if (v == 16'(LINES_PER_FRAME - 1)) begin
                    v_nx     = '0;
                    field_nx = ~field;
                end else begin
                    v_nx = v + 16'd1;
                end
            end else begin
                h_nx = h + 16'd1;
            end
        end
    end

    // Pixel-rate outputs for the dot that is about to start. mode and
    // solid are sampled here, so a change lands on the next dot boundary.
    always_comb begin
        x_nx   = h_nx[7:0];
        y_nx   = v_nx[7:0];
        hb_nx  = (h_nx >= 16'd256);
        vb_nx  = (v_nx >= 16'd224);
        ref_nx = (h_nx >= 16'(REFRESH_DOT)) &&
                 (h_nx < 16'(REFRESH_DOT + REFRESH_LEN));
        pat_nx = '0;
        case (mode)
            2'd0:    pat_nx = {y_nx[7:3], x_nx[7:3], x_nx[4:0] ^ y_nx[4:0]};
            2'd1:    pat_nx = x_nx[5] ? 15'h001F : 15'h7FFF;
            2'd2:    pat_nx = (x_nx[3] ^ y_nx[3]) ? 15'h7FFF : 15'h0000;
            default: pat_nx = solid;
        endcase
        rgb_nx = (hb_nx || vb_nx) ? 15'h0000 : pat_nx;
    end

    assign div_wrap = (div == 16'(AUDIO_DIV - 1));
    assign l_sum    = audio_l + AUDIO_STEP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph           <= '0;
            h            <= '0;
            v            <= '0;
            field        <= 1'b0;
            div          <= '0;
            dotclk       <= 1'b0;
            hblank       <= 1'b0;
            vblank       <= 1'b0;
            rgb5         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            snes_refresh <= 1'b0;
            audio_l      <= '0;
            audio_r      <= 16'hFFFF;
            ready_q      <= 1'b0;
        end else if (pause) begin
            // Everything holds, but any pending strobe is dropped so that
            // it is not shown a second time once the pause ends.
            ready_q <= 1'b0;
        end else begin
            ph     <= ph_nx;
            h      <= h_nx;
            v      <= v_nx;
            field  <= field_nx;
            dotclk <= (ph_nx >= 8'(DOT_HALF));
            if (dot_start) begin
                hblank       <= hb_nx;
                vblank       <= vb_nx;
                rgb5         <= rgb_nx;
                x_q          <= x_nx;
                y_q          <= y_nx;
                snes_refresh <= ref_nx;
            end
            div     <= div_wrap ? 16'd0 : div + 16'd1;
            ready_q <= div_wrap & audio_en;
            if (div_wrap && audio_en) begin
                audio_l <= l_sum;
                audio_r <= ~l_sum;
            end
        end
    end

    assign xs          = {x_q, dotclk};
    assign ys          = {field, y_q};
    // The mask makes the strobe drop in the same cycle that pause is raised.
    assign audio_ready = ready_q & ~pause;

endmodule

// File: tb/tb_snes_video_src.sv
module tb_snes_video_src;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst = 3'b111;
    logic        pause = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [14:0] solid = 15'd0;
    logic        audio_en = 1'b1;

    logic [2:0]        dotclk_w, hblank_w, vblank_w, refresh_w, ready_w;
    logic [2:0][14:0]  rgb_w;
    logic [2:0][8:0]   xs_w, ys_w;
    logic [2:0][15:0]  al_w, ar_w;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: unpaused cycles since reset, samples emitted,
    // expected strobe, and the mode/colour sampled at the last dot start.
    int          t     [3];
    int          nsamp [3];
    bit          rdy   [3];
    logic [1:0]  lm    [3];
    logic [14:0] ls    [3];

    // 0: default raster, fast audio; 1: tiny raster; 2: short lines, tall frame
    snes_video_src #(.AUDIO_DIV(10)) u_def (
        .clk(clk), .reset(rst[0]), .pause(pause), .mode(mode), .solid(solid),
        .audio_en(audio_en), .dotclk(dotclk_w[0]), .hblank(hblank_w[0]),
        .vblank(vblank_w[0]), .rgb5(rgb_w[0]), .xs(xs_w[0]), .ys(ys_w[0]),
        .snes_refresh(refresh_w[0]), .audio_l(al_w[0]), .audio_r(ar_w[0]),
        .audio_ready(ready_w[0]));

    snes_video_src #(.DOT_HALF(2), .DOTS_PER_LINE(8), .LINES_PER_FRAME(4),
                     .AUDIO_DIV(7), .AUDIO_STEP(16'd1000)) u_small (
        .clk(clk), .reset(rst[1]), .pause(pause), .mode(mode), .solid(solid),
        .audio_en(audio_en), .dotclk(dotclk_w[1]), .hblank(hblank_w[1]),
        .vblank(vblank_w[1]), .rgb5(rgb_w[1]), .xs(xs_w[1]), .ys(ys_w[1]),
        .snes_refresh(refresh_w[1]), .audio_l(al_w[1]), .audio_r(ar_w[1]),
        .audio_ready(ready_w[1]));

    snes_video_src #(.DOT_HALF(1), .DOTS_PER_LINE(8), .LINES_PER_FRAME(262),
                     .REFRESH_DOT(3), .REFRESH_LEN(2)) u_tall (
        .clk(clk), .reset(rst[2]), .pause(pause), .mode(mode), .solid(solid),
        .audio_en(audio_en), .dotclk(dotclk_w[2]), .hblank(hblank_w[2]),
        .vblank(vblank_w[2]), .rgb5(rgb_w[2]), .xs(xs_w[2]), .ys(ys_w[2]),
        .snes_refresh(refresh_w[2]), .audio_l(al_w[2]), .audio_r(ar_w[2]),
        .audio_ready(ready_w[2]));

    function automatic int p_dh(int i);  return (i == 2) ? 1 : 2; endfunction
    function automatic int p_dpl(int i); return (i == 0) ? 341 : 8; endfunction
    function automatic int p_lpf(int i); return (i == 1) ? 4 : 262; endfunction
    function automatic int p_rd(int i);  return (i == 2) ? 3 : 134; endfunction
    function automatic int p_rl(int i);  return (i == 2) ? 2 : 10; endfunction
    function automatic int p_ad(int i);  return (i == 0) ? 10 : (i == 1) ? 7 : 671; endfunction
    function automatic int p_as(int i);  return (i == 1) ? 1000 : 64; endfunction

    function automatic logic [14:0] pattern(logic [1:0] m, logic [14:0] s,
                                            logic [7:0] x, logic [7:0] y);
        case (m)
            2'd0:    return {y[7:3], x[7:3], x[4:0] ^ y[4:0]};
            2'd1:    return ((x / 32) % 2 == 0) ? 15'h7FFF : 15'h001F;
            2'd2:    return (x[3] != y[3]) ? 15'h7FFF : 15'h0000;
            default: return s;
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(int i);
        int dh, ph, d, h, line, v, fld;
        logic        edc, ehb, evb, eref;
        logic [8:0]  exs, eys;
        logic [14:0] ergb;
        logic [15:0] el, er;
        dh   = p_dh(i);
        ph   = t[i] % (2 * dh);
        d    = t[i] / (2 * dh);
        h    = d % p_dpl(i);
        line = d / p_dpl(i);
        v    = line % p_lpf(i);
        fld  = (line / p_lpf(i)) % 2;
        edc  = (ph >= dh);
        if (d == 0) begin
            // Dot 0 after reset still shows the reset values.
            ehb = 1'b0; evb = 1'b0; eref = 1'b0; ergb = 15'd0;
            exs = {8'd0, edc};
            eys = 9'd0;
        end else begin
            ehb  = (h >= 256);
            evb  = (v >= 224);
            eref = (h >= p_rd(i)) && (h < p_rd(i) + p_rl(i));
            exs  = {8'(h), edc};
            eys  = {1'(fld), 8'(v)};
            ergb = (ehb || evb) ? 15'd0 : pattern(lm[i], ls[i], 8'(h), 8'(v));
        end
        el = 16'(nsamp[i] * p_as(i));
        er = ~el;
        chk($sformatf("dotclk%0d", i),  dotclk_w[i],  edc);
        chk($sformatf("hblank%0d", i),  hblank_w[i],  ehb);
        chk($sformatf("vblank%0d", i),  vblank_w[i],  evb);
        chk($sformatf("refresh%0d", i), refresh_w[i], eref);
        chk($sformatf("xs%0d", i),      xs_w[i],      exs);
        chk($sformatf("ys%0d", i),      ys_w[i],      eys);
        chk($sformatf("rgb%0d", i),     rgb_w[i],     ergb);
        chk($sformatf("audio_l%0d", i), al_w[i],      el);
        chk($sformatf("audio_r%0d", i), ar_w[i],      er);
        chk($sformatf("ready%0d", i),   ready_w[i],   rdy[i]);
    endtask

    // One clock: inputs are sampled as they stand at the rising edge, the
    // model advances, and all outputs are checked on the falling edge.
    task automatic step();
        logic [2:0]  r;
        logic        p, ae;
        logic [1:0]  m;
        logic [14:0] s;
        r = rst; p = pause; ae = audio_en; m = mode; s = solid;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r[i]) begin
                t[i] = 0; nsamp[i] = 0; rdy[i] = 1'b0;
            end else if (p) begin
                rdy[i] = 1'b0;
            end else begin
                t[i]++;
                rdy[i] = 1'b0;
                if (t[i] % p_ad(i) == 0 && ae) begin
                    nsamp[i]++;
                    rdy[i] = 1'b1;
                end
                if (t[i] % (2 * p_dh(i)) == 0) begin
                    lm[i] = m;
                    ls[i] = s;
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_inst(i);
    endtask

    task automatic run_to(int i, int target, string tag);
        int g;
        g = 0;
        while (t[i] < target && g < 60000) begin
            step();
            g++;
        end
        chk(tag, t[i], target);
    endtask

    function automatic logic [63:0] vid(int i);
        return {27'd0, dotclk_w[i], hblank_w[i], vblank_w[i], rgb_w[i],
                xs_w[i], ys_w[i], refresh_w[i]};
    endfunction

    initial begin
        int k, last, prev, last_rise, cnt, first_t, n;
        logic [63:0] cap_v, cap_a;
        logic [7:0]  x0;
        logic [15:0] exp_l, exp_r;

        for (int i = 0; i < 3; i++) begin
            t[i] = 0; nsamp[i] = 0; rdy[i] = 1'b0; lm[i] = 2'd0; ls[i] = 15'd0;
        end

        // Reset state
        step();
        step();
        chk("rst_audio_r", ar_w[0], 16'hFFFF);
        chk("rst_xs", xs_w[0], 9'd0);
        @(negedge clk);
        rst = 3'b000;

        // Sawtooth strobes every 10 cycles
        k = 0; last = 0;
        for (int c = 0; c < 100 && k < 3; c++) begin
            step();
            if (ready_w[0]) begin
                k++;
                exp_l = 16'(64 * k);
                exp_r = ~exp_l;
                chk("strobe_l", al_w[0], exp_l);
                chk("strobe_r", ar_w[0], exp_r);
                chk("strobe_gap", t[0] - last, 10);
                last = t[0];
            end
        end
        chk("strobe_count", k, 3);

        // Dropped sample while the sink is not ready
        audio_en = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (ready_w[0]) cnt++;
        end
        chk("drop_no_strobe", cnt, 0);
        chk("drop_hold_l", al_w[0], 16'd192);
        audio_en = 1'b1;
        n = 0;
        while (!ready_w[0] && n < 20) begin
            step();
            n++;
        end
        chk("drop_next_gap", t[0] - last, 20);
        chk("drop_next_l", al_w[0], 16'd256);

        // Tiny raster: dot period, line wrap, field toggle
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        prev = dotclk_w[1]; last_rise = -1;
        for (int c = 0; c < 32; c++) begin
            step();
            if (prev == 0 && dotclk_w[1]) begin
                if (last_rise >= 0) chk("dotclk_period", t[1] - last_rise, 4);
                last_rise = t[1];
            end
            prev = dotclk_w[1];
        end
        chk("small_xs_8dots", xs_w[1], 9'd0);
        run_to(1, 128, "small_reach128");
        chk("small_ys_32dots", ys_w[1], 9'h100);

        // Randomised modes, colours, pauses and sink readiness
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) solid = 15'($urandom);
            audio_en = ($urandom_range(0, 3) != 0);
            pause = ($urandom_range(0, 9) == 0);
            step();
        end
        pause = 1'b0;
        mode = 2'd0;
        audio_en = 1'b1;

        // Default raster: hblank at h=256, refresh window, pause, pixel
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        run_to(0, 256 * 4, "def_reach_h256");
        chk("hblank_h256", hblank_w[0], 1'b1);
        chk("rgb_h256", rgb_w[0], 15'd0);
        run_to(0, 1364, "def_reach_line1");
        cnt = 0; first_t = -1;
        for (int c = 0; c < 1364; c++) begin
            step();
            if (refresh_w[0]) begin
                cnt++;
                if (first_t < 0) first_t = t[0];
            end
        end
        chk("refresh_cycles", cnt, 40);
        chk("refresh_start", first_t, 1364 + 134 * 4);

        n = 0;
        while (t[0] % 4 != 1 && n < 10) begin
            step();
            n++;
        end
        chk("pause_mid_dot", t[0] % 4, 1);
        cap_v = vid(0);
        cap_a = {32'd0, al_w[0], ar_w[0]};
        pause = 1'b1;
        for (int c = 0; c < 37; c++) begin
            step();
            chk("pause_video_hold", vid(0), cap_v);
            chk("pause_audio_hold", {32'd0, al_w[0], ar_w[0]}, cap_a);
            chk("pause_ready_low", ready_w[0], 1'b0);
        end
        pause = 1'b0;
        x0 = xs_w[0][8:1];
        n = 0;
        do begin
            step();
            n++;
        end while (xs_w[0][8:1] == x0 && n < 20);
        chk("resume_phase_left", n, 3);

        run_to(0, (10 * 341 + 5) * 4, "def_reach_h5v10");
        chk("rgb_h5_v10", rgb_w[0], {5'd1, 5'd0, 5'd15});

        // Tall frame: mid-frame reset, vblank, field toggle
        rst[2] = 1'b1;
        step();
        rst[2] = 1'b0;
        run_to(2, 100 * 16 + 5, "tall_reach_v100");
        chk("tall_y100", ys_w[2], 9'd100);
        #1 rst[2] = 1'b1;
        #1;
        chk("arst_dotclk", dotclk_w[2], 1'b0);
        chk("arst_hblank", hblank_w[2], 1'b0);
        chk("arst_vblank", vblank_w[2], 1'b0);
        chk("arst_rgb", rgb_w[2], 15'd0);
        chk("arst_xs", xs_w[2], 9'd0);
        chk("arst_ys", ys_w[2], 9'd0);
        chk("arst_refresh", refresh_w[2], 1'b0);
        chk("arst_audio_l", al_w[2], 16'd0);
        chk("arst_audio_r", ar_w[2], 16'hFFFF);
        chk("arst_ready", ready_w[2], 1'b0);
        step();
        rst[2] = 1'b0;
        step();
        chk("after_rst_x0", xs_w[2][8:1], 8'd0);
        chk("after_rst_y0", ys_w[2], 9'd0);
        step();
        chk("after_rst_x1", xs_w[2][8:1], 8'd1);
        run_to(2, 224 * 16, "tall_reach_v224");
        chk("vblank_v224", vblank_w[2], 1'b1);
        chk("rgb_vblank", rgb_w[2], 15'd0);
        run_to(2, 262 * 16, "tall_reach_frame1");
        chk("field_toggle", ys_w[2], 9'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
